// File: rtl/data_memory_mc_if.sv
// data_memory_mc_if: MEM-stage request/response bundle for the multi-cycle data memory
interface data_memory_mc_if #(parameter int ADDR_WIDTH = 32);
  logic MemRead, MemWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0] write_data;
  logic [1:0] size;
  logic sign_ext;
  logic [31:0] read_data;
  logic ready, rvalid, addr_error;
  modport master (output MemRead, MemWrite, address, write_data, size, sign_ext,
                  input read_data, ready, rvalid, addr_error);
  modport slave (input MemRead, MemWrite, address, write_data, size, sign_ext,
                 output read_data, ready, rvalid, addr_error);
endinterface

// File: rtl/data_memory_mc.sv
// data_memory_mc: multi-cycle byte/half/word data memory with ready/rvalid handshake
module data_memory_mc #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic reset_n,
  data_memory_mc_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = 4;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [1:0] lane, sz;
  logic [31:0] wdata, word, merged, loaded, read_data;
  logic sext, op_write, req, bad, done, ready, rvalid, addr_error;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  assign req = bus.MemRead | bus.MemWrite;
  assign bad = (bus.MemRead & bus.MemWrite) | (bus.size == 2'b11) |
               (bus.size == 2'b01 & bus.address[0]) | (bus.size == 2'b10 & |bus.address[1:0]) |
               (64'(bus.address) >= 64'(4 * DEPTH_WORDS));
  assign done = state == BUSY && cnt == '0;
  assign word = mem[idx];
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];
  assign loaded = sz == 2'b00 ? {{24{sext & byte_sel[7]}}, byte_sel} :
                  sz == 2'b01 ? {{16{sext & half_sel[15]}}, half_sel} : word;
  always_comb begin
    merged = word;
    if (sz == 2'b00) merged[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (sz == 2'b01) merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
  // Storage has no reset; an aborted access never reaches done, so nothing is written
  always_ff @(posedge clk)
    if (done && op_write) mem[idx] <= merged;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ready <= 1'b1;
      read_data <= '0;
      rvalid <= 1'b0;
      addr_error <= 1'b0;
      cnt <= '0;
      idx <= '0;
      lane <= '0;
      sz <= '0;
      wdata <= '0;
      sext <= 1'b0;
      op_write <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      addr_error <= 1'b0;
      if (state == IDLE) begin
        if (req && bad) addr_error <= 1'b1;
        else if (req) begin
          state <= BUSY;
          ready <= 1'b0;
          cnt <= CW'(LATENCY - 1);
          idx <= bus.address[IW+1:2];
          lane <= bus.address[1:0];
          sz <= bus.size;
          wdata <= bus.write_data;
          sext <= bus.sign_ext;
          op_write <= bus.MemWrite;
        end
      end else if (cnt == '0) begin
        state <= IDLE;
        ready <= 1'b1;
        if (!op_write) begin
          read_data <= loaded;
          rvalid <= 1'b1;
        end
      end else cnt <= cnt - 1'b1;
    end
  assign bus.read_data = read_data;
  assign bus.ready = ready;
  assign bus.rvalid = rvalid;
  assign bus.addr_error = addr_error;
endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: directed bench with a byte-array reference model over LATENCY 2, 1 and 4
module tb_data_memory_mc;
  typedef struct packed {logic ready; logic rvalid; logic err; logic [31:0] rd;} exp_t;
  logic clk = 1'b0, reset_n = 1'b1, en = 1'b0;
  logic mr = 0, mw = 0, se = 0;
  logic [31:0] addr = 0, wd = 0;
  logic [1:0] sz = 0;
  int sel = 0, n_cmp = 0, n_bad = 0, lowc = 0;
  logic [7:0] mm [3][1024];
  logic [31:0] rd_m [3];
  exp_t q[$];
  exp_t ce;
  logic ready_o, rvalid_o, err_o;
  logic [31:0] rd_o;
  always #5 clk = ~clk;
  data_memory_mc_if #(.ADDR_WIDTH(32)) if2();
  data_memory_mc_if #(.ADDR_WIDTH(32)) if1();
  data_memory_mc_if #(.ADDR_WIDTH(32)) if4();
  data_memory_mc #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_WIDTH(32)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));
  data_memory_mc #(.DEPTH_WORDS(256), .LATENCY(1), .ADDR_WIDTH(32)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  data_memory_mc #(.DEPTH_WORDS(256), .LATENCY(4), .ADDR_WIDTH(32)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  assign if2.MemRead = mr & (sel == 0);
  assign if2.MemWrite = mw & (sel == 0);
  assign if2.address = addr;
  assign if2.write_data = wd;
  assign if2.size = sz;
  assign if2.sign_ext = se;
  assign if1.MemRead = mr & (sel == 1);
  assign if1.MemWrite = mw & (sel == 1);
  assign if1.address = addr;
  assign if1.write_data = wd;
  assign if1.size = sz;
  assign if1.sign_ext = se;
  assign if4.MemRead = mr & (sel == 2);
  assign if4.MemWrite = mw & (sel == 2);
  assign if4.address = addr;
  assign if4.write_data = wd;
  assign if4.size = sz;
  assign if4.sign_ext = se;
  assign ready_o = sel == 0 ? if2.ready : sel == 1 ? if1.ready : if4.ready;
  assign rvalid_o = sel == 0 ? if2.rvalid : sel == 1 ? if1.rvalid : if4.rvalid;
  assign err_o = sel == 0 ? if2.addr_error : sel == 1 ? if1.addr_error : if4.addr_error;
  assign rd_o = sel == 0 ? if2.read_data : sel == 1 ? if1.read_data : if4.read_data;
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int lat(int k);
    return k == 0 ? 2 : k == 1 ? 1 : 4;
  endfunction
  function automatic bit rej(bit r, bit w, logic [31:0] a, logic [1:0] s);
    return (r && w) || s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 0) || a >= 32'd1024;
  endfunction
  function automatic logic [31:0] ld(int k, logic [31:0] a, logic [1:0] s, bit x);
    logic [15:0] h;
    h = {mm[k][a[9:0] + 10'd1], mm[k][a[9:0]]};
    if (s == 2'b00) return {{24{x & mm[k][a[9:0]][7]}}, mm[k][a[9:0]]};
    if (s == 2'b01) return {{16{x & h[15]}}, h};
    return {mm[k][a[9:0] + 10'd3], mm[k][a[9:0] + 10'd2], h};
  endfunction
  task automatic st(int k, logic [31:0] a, logic [31:0] d, logic [1:0] s);
    int n;
    n = s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
    for (int i = 0; i < n; i++) mm[k][a[9:0] + 10'(i)] = d[8*i +: 8];
  endtask
  always @(negedge clk) if (en) begin
    ce = q.size() != 0 ? q.pop_front() : '{1'b1, 1'b0, 1'b0, rd_m[sel]};
    if (ready_o === 1'b0) lowc++;
    chk("ready", 32'(ready_o), 32'(ce.ready));
    chk("rvalid", 32'(rvalid_o), 32'(ce.rvalid));
    chk("addr_error", 32'(err_o), 32'(ce.err));
    chk("read_data", rd_o, ce.rd);
  end
  task automatic acc(bit r, bit w, logic [31:0] a, logic [31:0] d, logic [1:0] s, bit x,
                     bit intr = 0, logic [31:0] a2 = 0, logic [31:0] d2 = 0);
    int l;
    bit rj;
    logic [31:0] old;
    l = lat(sel);
    old = rd_m[sel];
    rj = rej(r, w, a, s);
    mr = r; mw = w; addr = a; wd = d; sz = s; se = x; lowc = 0;
    if (rj) q.push_back('{1'b1, 1'b0, 1'b1, old});
    else begin
      repeat (l) q.push_back('{1'b0, 1'b0, 1'b0, old});
      if (w) st(sel, a, d, s);
      else rd_m[sel] = ld(sel, a, s, x);
      q.push_back('{1'b1, !w, 1'b0, rd_m[sel]});
    end
    @(negedge clk); #1;
    if (intr) begin
      addr = a2; wd = d2;
      repeat (l) begin @(negedge clk); #1; end
    end
    mr = 0; mw = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin @(negedge clk); #1; end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    chk("busy_width", lowc, rj ? 0 : l);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rd_m[k] = 0;
      for (int i = 0; i < 1024; i++) mm[k][i] = 8'h00;
    end
    #1 reset_n = 1'b0;
    en = 1'b1;
    #1 chk("reset_ready", 32'(ready_o), 1);
    chk("reset_rd", rd_o, 0);
    chk("reset_rvalid", 32'(rvalid_o), 0);
    chk("reset_err", 32'(err_o), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    acc(0, 1, 32'h4, 32'h11111111, 2'b10, 0);
    acc(0, 1, 32'h8, 32'h22222222, 2'b10, 0);
    acc(1, 0, 32'h4, 0, 2'b10, 0);
    chk("lw_4", rd_o, 32'h11111111);
    acc(1, 0, 32'h8, 0, 2'b10, 0);
    chk("lw_8", rd_o, 32'h22222222);
    acc(0, 1, 32'h5, 32'h00000080, 2'b00, 0);
    acc(1, 0, 32'h4, 0, 2'b10, 0);
    chk("lw_4_sb", rd_o, 32'h11118011);
    acc(1, 0, 32'h5, 0, 2'b00, 1);
    chk("lb_5", rd_o, 32'hFFFFFF80);
    acc(1, 0, 32'h5, 0, 2'b00, 0);
    chk("lbu_5", rd_o, 32'h00000080);
    acc(0, 1, 32'hA, 32'h0000BEEF, 2'b01, 0);
    acc(1, 0, 32'h8, 0, 2'b10, 0);
    chk("lw_8_sh", rd_o, 32'hBEEF2222);
    acc(1, 0, 32'hA, 0, 2'b01, 1);
    chk("lh_a", rd_o, 32'hFFFFBEEF);
    acc(1, 0, 32'hA, 0, 2'b01, 0);
    chk("lhu_a", rd_o, 32'h0000BEEF);
    acc(1, 0, 32'h6, 0, 2'b10, 0);
    acc(1, 0, 32'h3, 0, 2'b01, 0);
    acc(1, 0, 32'h4, 0, 2'b11, 0);
    acc(1, 0, 32'h400, 0, 2'b10, 0);
    acc(1, 1, 32'h4, 32'h0, 2'b10, 0);
    acc(0, 1, 32'h6, 32'hFFFFFFFF, 2'b10, 0);
    chk("rd_after_rejects", rd_o, 32'h0000BEEF);
    acc(1, 0, 32'h4, 0, 2'b10, 0);
    chk("lw_4_after_rejects", rd_o, 32'h11118011);
    acc(0, 1, 32'hC, 32'h0, 2'b10, 0);
    mw = 1; addr = 32'hC; wd = 32'hDEADBEEF; sz = 2'b10; se = 0;
    q.push_back('{1'b0, 1'b0, 1'b0, rd_m[0]});
    @(negedge clk); #1;
    mw = 0;
    reset_n = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) rd_m[k] = 0;
    #1 chk("abort_ready", 32'(ready_o), 1);
    chk("abort_rd", rd_o, 0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    acc(1, 0, 32'hC, 0, 2'b10, 0);
    chk("lw_c_after_abort", rd_o, 32'h00000000);
    for (int k = 1; k < 3; k++) begin
      sel = k;
      @(negedge clk); #1;
      acc(0, 1, 32'h14, 32'h12345678, 2'b10, 0);
      acc(0, 1, 32'h10, 32'hCAFEF00D, 2'b10, 0, 1, 32'h14, 32'h55555555);
      acc(1, 0, 32'h10, 0, 2'b10, 0);
      chk("sweep_lw_10", rd_o, 32'hCAFEF00D);
      acc(1, 0, 32'h14, 0, 2'b10, 0);
      chk("sweep_lw_14", rd_o, 32'h12345678);
    end
    @(negedge clk); #1;
    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_memory_mc.md
Name: data_memory_mc

Overview:
- Parametrised successor to the single-cycle data memory of the pipelined MIPS CPU; sits in the MEM stage.
- Adds byte, halfword and word access (sb/sh/sw, lb/lbu/lh/lhu) with little-endian lane select and sign/zero extension.
- Adds a configurable multi-cycle access latency, with a ready/rvalid handshake that the hazard unit uses to stall the pipeline.
- Adds alignment and range checking with a one-cycle error pulse.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 4.
- LATENCY, 2, cycles ready stays low per accepted access; legal range 1..15.
- ADDR_WIDTH, 32, width of the byte address input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MemRead  input  1  read request.
- MemWrite  input  1  write request.
- address  input  ADDR_WIDTH  byte address.
- write_data  input  32  store data; the low byte or halfword is used for sub-word stores.
- size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
- sign_ext  input  1  reads only: 1 sign-extends, 0 zero-extends sub-word loads.
- read_data  output  32  load result; holds its value until the next successful read completes.
- ready  output  1  1 = idle and able to accept a request.
- rvalid  output  1  one-cycle pulse when read_data has just been updated.
- addr_error  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Storage: DEPTH_WORDS x 32 array.
  - Word index = address[log2(DEPTH_WORDS)+1:2]; byte lane = address[1:0].
  - Contents are not affected by reset.
- Reset (asynchronous, reset_n=0):
  - state=IDLE, ready=1, read_data=0, rvalid=0, addr_error=0.
  - Reset asserted during BUSY aborts the access; a pending write is dropped and memory is unchanged.
- FSM states: IDLE, BUSY.
  - IDLE: ready=1. A request is sampled at a rising edge when MemRead|MemWrite=1.
  - Reject conditions (any one):
    - MemRead and MemWrite both 1;
    - size=11;
    - halfword with address[0]=1;
    - word with address[1:0]!=0;
    - address >= 4*DEPTH_WORDS.
  - On reject: addr_error=1 for exactly the next cycle, no memory access, stay IDLE, read_data unchanged.
  - On accept: latch address, write_data, size, sign_ext and op; counter=LATENCY-1; go to BUSY; ready=0 from the next cycle.
  - BUSY: ready=0, and the request inputs are ignored; the requester holds or stalls.
    - Counter decrements each edge.
    - At the edge where counter==0, perform the access and return to IDLE.
- Timing: accept at edge E0 -> ready=0 during cycles E0..E0+LATENCY -> access at edge E0+LATENCY -> ready=1 after that edge.
  - rvalid=1 for the one cycle after the completing edge, reads only.
  - Maximum throughput: one access per LATENCY+1 cycles; the next request can be sampled at edge E0+LATENCY+1.
- Writes (read-modify-write on the latched word):
  - Byte: mem[idx][8*lane+:8] = write_data[7:0].
  - Halfword: mem[idx][16*address[1]+:16] = write_data[15:0].
  - Word: full 32-bit replace.
- Reads:
  - Byte: lane byte, extended per sign_ext.
  - Halfword: the selected half, extended per sign_ext.
  - Word: sign_ext ignored.
- Same-address write then read: the read returns the newly written data, because accesses never overlap.
- addr_error and rvalid are never asserted in the same cycle.

Test Plan:
- Reset then LATENCY=2: sw 0x11111111 to 0x4, sw 0x22222222 to 0x8, lw 0x4, lw 0x8 -> read_data 0x11111111 then 0x22222222; ready low exactly 2 cycles per access; rvalid pulses once per read.
- sb 0x80 to 0x5 over word 0x11111111 at 0x4 -> lw 0x4 = 0x11118011; lb 0x5 = 0xFFFFFF80; lbu 0x5 = 0x00000080.
- sh 0xBEEF to 0xA over 0x22222222 -> lw 0x8 = 0xBEEF2222; lh 0xA = 0xFFFFBEEF; lhu 0xA = 0x0000BEEF.
- Rejects: lw 0x6, lh 0x3, size=11, address=0x400 (DEPTH 256), MemRead=MemWrite=1 -> each gives a one-cycle addr_error, ready stays 1, memory and read_data unchanged.
- reset_n pulsed low mid-BUSY on sw 0xDEADBEEF to 0xC (prior value 0x0) -> ready=1 immediately; lw 0xC returns 0x00000000.
- Sweep LATENCY=1 and 4 -> ready-low width equals LATENCY; requests asserted while busy are ignored, so exactly one write is observed.
